// File: rtl/sfp_pkg.sv
// rtl/sfp_pkg.sv - small-float format constants, word/stage structs and saturation helper
// Stage-2 struct carries guard/sticky only when SFP_MUL_RNE_EN is defined.
package sfp_pkg;

   localparam int EXP_W  = 4;
   localparam int SIG_W  = 4;
   localparam int FMT_W  = 1 + EXP_W + SIG_W;
   localparam int BIAS   = 2**(EXP_W-1);
   localparam int PROD_W = 2*(SIG_W+1);
   localparam int ESUM_W = EXP_W + 2;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [SIG_W-1:0] man;
   } sfp_t;

   localparam sfp_t SFP_ZERO = '0;

   function automatic sfp_t sfp_max(input logic sign);
      sfp_t w;
      w.sign = sign;
      w.exp  = '1;
      w.man  = '1;
      return w;
   endfunction

   typedef struct packed {
      logic              sign;
      logic              zero;
      logic [ESUM_W-1:0] exp_sum;
      logic [PROD_W-1:0] product;
   } sfp_s1_t;

   typedef struct packed {
      logic                     sign;
      logic                     zero;
      logic signed [ESUM_W-1:0] exp;
      logic [SIG_W-1:0]         man;
`ifdef SFP_MUL_RNE_EN
      logic                     guard;
      logic                     sticky;
`endif
   } sfp_s2_t;

endpackage

// File: rtl/sfp_mul_lane.sv
// rtl/sfp_mul_lane.sv - one multiplier lane as three combinational slices (unpack, normalise, round/pack)
// Round-to-nearest-even in S3 when SFP_MUL_RNE_EN is defined, truncation otherwise.
module sfp_mul_lane
   import sfp_pkg::*;
(
   input  sfp_t    i_a,
   input  sfp_t    i_b,
   output sfp_s1_t o_s1,
   input  sfp_s1_t i_s1,
   output sfp_s2_t o_s2,
   input  sfp_s2_t i_s2,
   output sfp_t    o_c,
   output logic    o_ovf,
   output logic    o_ufl
);

   localparam logic signed [ESUM_W-1:0] EXP_MAX  = ESUM_W'(2**EXP_W - 1);
   localparam logic signed [ESUM_W-1:0] EXP_MIN  = ESUM_W'(1);
   localparam logic signed [ESUM_W-1:0] EXP_BIAS = ESUM_W'(BIAS);

   logic                     w_norm;
   logic [PROD_W-1:0]        w_aligned;
   logic [SIG_W:0]           w_man_r;
   logic signed [ESUM_W-1:0] w_exp_r;
   logic                     w_unused_bits;

   always_comb begin
      o_s1         = '0;
      o_s1.sign    = i_a.sign ^ i_b.sign;
      o_s1.zero    = (i_a.exp == '0) || (i_b.exp == '0);
      o_s1.exp_sum = ESUM_W'(i_a.exp) + ESUM_W'(i_b.exp);
      o_s1.product = PROD_W'({1'b1, i_a.man}) * PROD_W'({1'b1, i_b.man});
   end

   // Product of two 1.x significands lies in [1,4); align so the hidden 1 sits at PROD_W-1.
   always_comb begin
      w_norm    = i_s1.product[PROD_W-1];
      w_aligned = w_norm ? i_s1.product : {i_s1.product[PROD_W-2:0], 1'b0};
      o_s2      = '0;
      o_s2.sign = i_s1.sign;
      o_s2.zero = i_s1.zero;
      o_s2.exp  = $signed(i_s1.exp_sum) + $signed(ESUM_W'(w_norm)) - EXP_BIAS;
      o_s2.man  = w_aligned[PROD_W-2 -: SIG_W];
`ifdef SFP_MUL_RNE_EN
      o_s2.guard  = w_aligned[PROD_W-2-SIG_W];
      o_s2.sticky = |w_aligned[PROD_W-3-SIG_W:0];
`endif
   end

`ifdef SFP_MUL_RNE_EN
   assign w_unused_bits = w_aligned[PROD_W-1];
`else
   assign w_unused_bits = ^{w_aligned[PROD_W-1], w_aligned[PROD_W-2-SIG_W:0]};
`endif

   always_comb begin
`ifdef SFP_MUL_RNE_EN
      w_man_r = {1'b0, i_s2.man} + (SIG_W+1)'(i_s2.guard && (i_s2.sticky || i_s2.man[0]));
`else
      w_man_r = {1'b0, i_s2.man};
`endif
      w_exp_r = i_s2.exp + $signed(ESUM_W'(w_man_r[SIG_W]));
      o_c     = SFP_ZERO;
      o_ovf   = 1'b0;
      o_ufl   = 1'b0;
      if (!i_s2.zero) begin
         if (w_exp_r > EXP_MAX) begin
            o_c   = sfp_max(i_s2.sign);
            o_ovf = 1'b1;
         end else if (w_exp_r < EXP_MIN) begin
            o_ufl = 1'b1;
         end else begin
            o_c.sign = i_s2.sign;
            o_c.exp  = w_exp_r[EXP_W-1:0];
            o_c.man  = w_man_r[SIG_W-1:0];
         end
      end
   end

endmodule

// File: rtl/sfp_hadamard_mul_pipe.sv
// rtl/sfp_hadamard_mul_pipe.sv - LANES-wide 3-stage small-float Hadamard multiplier with valid/ready and overflow counter
// Define SFP_MUL_RNE_EN to round to nearest even instead of truncating.
module sfp_hadamard_mul_pipe
   import sfp_pkg::*;
#(
   parameter int LANES = 4,
   parameter int CNT_W = 16
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_in_valid,
   output logic                   o_in_ready,
   input  logic [LANES*FMT_W-1:0] i_in_a,
   input  logic [LANES*FMT_W-1:0] i_in_b,
   output logic                   o_out_valid,
   input  logic                   i_out_ready,
   output logic [LANES*FMT_W-1:0] o_out_c,
   output logic [LANES-1:0]       o_out_ovf,
   output logic [LANES-1:0]       o_out_ufl,
   input  logic                   i_cnt_clr,
   output logic [CNT_W-1:0]       o_ovf_cnt
);

   logic                   w_adv;
   logic                   w_cnt_inc;
   logic                   r_v1, r_v2, r_v3;
   sfp_s1_t                w_s1 [LANES];
   sfp_s1_t                r_s1 [LANES];
   sfp_s2_t                w_s2 [LANES];
   sfp_s2_t                r_s2 [LANES];
   sfp_t                   w_c  [LANES];
   logic [LANES-1:0]       w_ovf, w_ufl;
   logic [LANES*FMT_W-1:0] r_c;
   logic [LANES-1:0]       r_ovf, r_ufl;
   logic [CNT_W-1:0]       r_cnt;

   // Whole pipeline moves as one; a stalled output freezes every stage.
   assign w_adv      = !r_v3 || i_out_ready;
   assign o_in_ready = w_adv;

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      sfp_mul_lane u_lane (
         .i_a   (i_in_a[gi*FMT_W +: FMT_W]),
         .i_b   (i_in_b[gi*FMT_W +: FMT_W]),
         .o_s1  (w_s1[gi]),
         .i_s1  (r_s1[gi]),
         .o_s2  (w_s2[gi]),
         .i_s2  (r_s2[gi]),
         .o_c   (w_c[gi]),
         .o_ovf (w_ovf[gi]),
         .o_ufl (w_ufl[gi])
      );
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_v1  <= 1'b0;
         r_v2  <= 1'b0;
         r_v3  <= 1'b0;
         r_c   <= '0;
         r_ovf <= '0;
         r_ufl <= '0;
         for (int i = 0; i < LANES; i++) begin
            r_s1[i] <= '0;
            r_s2[i] <= '0;
         end
      end else if (w_adv) begin
         r_v1  <= i_in_valid;
         r_v2  <= r_v1;
         r_v3  <= r_v2;
         r_ovf <= w_ovf;
         r_ufl <= w_ufl;
         for (int i = 0; i < LANES; i++) begin
            r_s1[i]                <= w_s1[i];
            r_s2[i]                <= w_s2[i];
            r_c[i*FMT_W +: FMT_W]  <= w_c[i];
         end
      end
   end

   assign w_cnt_inc = r_v3 && i_out_ready && (|r_ovf) && (r_cnt != '1);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_cnt_clr) begin
         r_cnt <= '0;
      end else if (w_cnt_inc) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_out_valid = r_v3;
   assign o_out_c     = r_c;
   assign o_out_ovf   = r_ovf;
   assign o_out_ufl   = r_ufl;
   assign o_ovf_cnt   = r_cnt;

endmodule

// File: doc/sfp_hadamard_mul_pipe.md
Name: sfp_hadamard_mul_pipe

Overview:
- Pipelined, multi-lane small-float multiplier for element-wise (Hadamard) products in the FFT/Hadamard datapath.
- Each beat multiplies LANES operand pairs in the {sign, exponent, mantissa} format with a hidden leading 1 and no denormals.
- Sits between the operand buffers and the accumulator stage. Uses a valid/ready stream on both sides.
- Adds three things the single-lane combinational multiplier lacks: overflow saturation, explicit underflow flush with flags, and an event counter.

Parameters:
- EXP_W, 4, exponent field width
- SIG_W, 4, stored mantissa width
- FMT_W, 1+EXP_W+SIG_W (9), word width; derived, not overridable
- BIAS, 2**(EXP_W-1) (8), exponent bias
- LANES, 4, parallel multipliers per beat
- CNT_W, 16, overflow event counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand beat valid
- in_ready  out  1  operand beat accepted when in_valid && in_ready
- in_a  in  LANES*FMT_W  operand A; lane i at [i*FMT_W +: FMT_W]
- in_b  in  LANES*FMT_W  operand B; same packing
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts
- out_c  out  LANES*FMT_W  products, same packing
- out_ovf  out  LANES  per-lane overflow (saturated) flag
- out_ufl  out  LANES  per-lane underflow (flushed) flag
- cnt_clr  in  1  synchronous clear of ovf_cnt
- ovf_cnt  out  CNT_W  count of transferred beats with any out_ovf bit set

Behaviour:
- Reset: asynchronous and active-high on every register. All stage valids, out_valid, out_c, out_ovf, out_ufl and ovf_cnt reset to 0. in_ready = 1 once rst deasserts.
- Pipeline: 3 stages.
  - S1: unpack, zero detect, (SIG_W+1)x(SIG_W+1) product, exponent sum ea+eb.
  - S2: normalise. If product MSB is set, shift right 1 and add 1 to the exponent. Compute guard and sticky bits.
  - S3: round, saturate/flush, pack.
- Latency: 3 cycles from input handshake to out_valid when there are no stalls. Throughput: 1 beat/cycle.
- Flow control:
  - adv = !out_valid || out_ready; all stages shift together when adv = 1.
  - in_ready = adv.
  - Stalls hold all stage contents. Bubbles propagate with valid = 0.
  - Data never drops or duplicates.
  - out_c, out_ovf and out_ufl stay stable while out_valid && !out_ready.
- Arithmetic per lane:
  - Sign: sa ^ sb.
  - e = ea + eb + norm - BIAS, computed signed with width EXP_W+2.
  - Either exponent field = 0 → result all-zero word (+0); ovf = 0, ufl = 0.
  - After rounding, e > 2**EXP_W - 1 → saturate to {sign, all-ones exponent, all-ones mantissa}; ovf = 1.
  - e < 1 → flush to all-zero word (+0); ufl = 1.
  - A rounding carry out of the mantissa increments e. It can push e into saturation; it cannot leave underflow.
- Counter:
  - ovf_cnt increments on each output handshake where |out_ovf is set, and saturates at all-ones.
  - cnt_clr has priority over a simultaneous increment; result is 0 that cycle.
- Reset mid-operation: in-flight beats are discarded and the counter is cleared.

Optional Feature:
- Macro: SFP_MUL_RNE_EN.
- Defined: S3 rounds to nearest even. Round up when guard && (sticky || mantissa LSB).
- Undefined: truncation. Guard and sticky are ignored and the rounding logic is not synthesised.
- Latency is identical in both builds.

Decomposition:
- Package sfp_pkg holds:
  - localparams EXP_W/SIG_W/FMT_W/BIAS defaults;
  - the sfp_t struct typedef {sign, exp, man};
  - SFP_ZERO and the sfp_max(sign) saturation constant;
  - the unpacked-stage struct (sign, zero, exp_sum, product).
- One sub-module, sfp_mul_lane: single-lane combinational datapath split into S1/S2/S3 slices. It is instantiated LANES times by a generate loop.
- Valid/ready control and the counter stay in the top module.

Test Plan (EXP_W=4, SIG_W=4, BIAS=8; lane 0 shown, other lanes replicate):
- Basic: 0x088 x 0x088 (1.5 x 1.5) → 0x092 (2.25) three cycles later; ovf = 0, ufl = 0.
- Sign/normalise: 0x190 x 0x098 (-2 x 3) → 0x1A8 (-6).
- Zero and underflow:
  - 0x000 x 0x088 → 0x000, flags 0.
  - 0x010 x 0x010 → 0x000 with ufl = 1.
- Overflow:
  - 0x0FF x 0x0FF → 0x0FF with ovf = 1.
  - Ten such beats → ovf_cnt = 10.
  - cnt_clr asserted together with an 11th overflow beat → ovf_cnt = 0.
- Rounding: 0x083 x 0x083 (1.1875²).
  - With SFP_MUL_RNE_EN → 0x087.
  - Without → 0x086.
- Backpressure/reset:
  - Random out_ready with continuous in_valid → outputs match a reference queue in order, held stable during stalls.
  - rst pulsed with 2 beats in flight → out_valid = 0 immediately; no stale beat emerges.
